bls_dispatch_controller: RTL and testbench

- Parametrised successor to the single-pricer controller. Sequences NUM_MODS Black-Scholes pricing modules against the option-data controller.
- Requests operand refills one module at a time, using round-robin, registered serve_reg pulses.
- Launches each pricer with registered bs_start pulses and tracks per-module in-flight jobs.
- Drains cleanly on out_of_data, with a watchdog. Exposes cycle and job counters for the LED and status readback.

---
 rtl/bls_dispatch_controller.sv | 130 +++++++++++++
 tb/tb_bls_dispatch_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bls_dispatch_controller.sv
// bls_dispatch_controller: round-robin refill and launch sequencer for NUM_MODS Black-Scholes pricers
module bls_dispatch_controller #(
  parameter int NUM_MODS = 4,
  parameter int CYC_W = 32,
  parameter int LED_W = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_system_i,
  input  logic                out_of_data_i,
  input  logic [NUM_MODS-1:0] bs_ready_i,
  input  logic [NUM_MODS-1:0] bs_done_i,
  input  logic [NUM_MODS-1:0] bs_idle_i,
  input  logic [NUM_MODS-1:0] has_unused_data_i,
  output logic [NUM_MODS-1:0] bs_start_o,
  output logic [NUM_MODS-1:0] serve_reg_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_err_o,
  output logic [CYC_W-1:0]    cycle_count_o,
  output logic [CYC_W-1:0]    jobs_started_o,
  output logic [CYC_W-1:0]    jobs_completed_o,
  output logic [LED_W-1:0]    led_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PW = (NUM_MODS > 1) ? $clog2(NUM_MODS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [NUM_MODS-1:0] inflight_q, inflight_d, pending_q, pending_d;
  logic [NUM_MODS-1:0] bs_start_q, bs_start_d, serve_q, serve_d;
  logic [NUM_MODS-1:0] live, eligible, cand, grant;
  logic [PW-1:0] rr_q, rr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, js_q, js_d, jc_q, jc_d;
  logic terr_q, terr_d;
  logic launch, drain_clear, wd_fire, found;
  int idx;
  function automatic logic [CYC_W-1:0] popc(input logic [NUM_MODS-1:0] v);
    popc = '0;
    for (int i = 0; i < NUM_MODS; i++) popc = popc + CYC_W'(v[i]);
  endfunction
  function automatic logic [CYC_W-1:0] sat_add(input logic [CYC_W-1:0] a, input logic [CYC_W-1:0] b);
    logic [CYC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CYC_W] ? '1 : s[CYC_W-1:0];
  endfunction
  assign drain_clear = inflight_q == '0 && pending_q == '0 && has_unused_data_i == '0 && &bs_idle_i;
  assign wd_fire = wd_q == WD_LAST;
  // state register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: start from IDLE/DONE, drain on out_of_data, finish on clean drain or watchdog
  always_comb begin
    state_d = state_q;
    if ((state_q == IDLE || state_q == DONE) && start_system_i) state_d = RUN;
    else if (state_q == RUN && out_of_data_i) state_d = DRAIN;
    else if (state_q == DRAIN && (drain_clear || wd_fire)) state_d = DONE;
  end
  // state-decoded and registered outputs
  always_comb begin
    busy_o = state_q == RUN || state_q == DRAIN;
    done_o = state_q == DONE;
    bs_start_o = bs_start_q;
    serve_reg_o = serve_q;
    timeout_err_o = terr_q;
    cycle_count_o = cyc_q;
    jobs_started_o = js_q;
    jobs_completed_o = jc_q;
    led_o = cyc_q[LED_W-1:0];
  end
  // launch, refill arbitration, job tracking, watchdog and counters
  always_comb begin
    launch = state_d == RUN && (state_q == IDLE || state_q == DONE);
    live = inflight_q & ~bs_done_i;
    eligible = has_unused_data_i & bs_ready_i & ~live;
    bs_start_d = (busy_o && state_d != DONE) ? eligible : '0;
    cand = (state_q == RUN && !out_of_data_i) ? ~has_unused_data_i & ~inflight_q & ~pending_q : '0;
    grant = '0;
    found = 1'b0;
    idx = 0;
    rr_d = rr_q;
    for (int k = 0; k < NUM_MODS; k++) begin
      idx = (int'(rr_q) + k) % NUM_MODS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        rr_d = PW'((idx + 1) % NUM_MODS);
      end
    end
    rr_d = launch ? '0 : rr_d;
    serve_d = grant;
    inflight_d = launch ? '0 : live | bs_start_d;
    pending_d = launch ? '0 : (pending_q & ~has_unused_data_i & {NUM_MODS{~out_of_data_i}}) | grant;
    wd_d = (state_q == DRAIN && state_d == DRAIN && bs_done_i == '0) ? wd_q + WW'(1) : '0;
    cyc_d = launch ? '0 : busy_o ? sat_add(cyc_q, CYC_W'(1)) : cyc_q;
    js_d = launch ? '0 : sat_add(js_q, popc(bs_start_q));
    jc_d = launch ? '0 : sat_add(jc_q, popc(bs_done_i));
    terr_d = launch ? 1'b0 : (state_q == DRAIN && state_d == DONE && !drain_clear) ? 1'b1 : terr_q;
  end
  // datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      inflight_q <= '0;
      pending_q <= '0;
      bs_start_q <= '0;
      serve_q <= '0;
      rr_q <= '0;
      wd_q <= '0;
      cyc_q <= '0;
      js_q <= '0;
      jc_q <= '0;
      terr_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      pending_q <= pending_d;
      bs_start_q <= bs_start_d;
      serve_q <= serve_d;
      rr_q <= rr_d;
      wd_q <= wd_d;
      cyc_q <= cyc_d;
      js_q <= js_d;
      jc_q <= jc_d;
      terr_q <= terr_d;
    end
  end
endmodule

// File: tb/tb_bls_dispatch_controller.sv
// tb_bls_dispatch_controller: random and directed stimulus against a behavioural model of the dispatcher
module tb_bls_dispatch_controller;
  localparam int N = 4, CW = 10, LW = 8, TO = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst = 1, ss = 0, ood = 0;
  logic [N-1:0] rdy = 0, dn = 0, idl = 0, has = 0;
  logic [N-1:0] bs_start, serve;
  logic busy, done, terr;
  logic [CW-1:0] cyc, js, jc;
  logic [LW-1:0] led;
  int total = 0, bad = 0;
  int m_st, m_rr, m_wd, m_cyc, m_js, m_jc;
  logic [N-1:0] m_inf, m_pend, m_bs, m_srv;
  bit m_to;
  always #5 clk = ~clk;
  bls_dispatch_controller #(.NUM_MODS(N), .CYC_W(CW), .LED_W(LW), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst), .start_system_i(ss), .out_of_data_i(ood),
    .bs_ready_i(rdy), .bs_done_i(dn), .bs_idle_i(idl), .has_unused_data_i(has),
    .bs_start_o(bs_start), .serve_reg_o(serve), .busy_o(busy), .done_o(done),
    .timeout_err_o(terr), .cycle_count_o(cyc), .jobs_started_o(js),
    .jobs_completed_o(jc), .led_o(led));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pop(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction
  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction
  // model state: 0 idle, 1 run, 2 drain, 3 done
  task automatic model_step();
    int nst, nrr, nwd;
    logic [N-1:0] nbs, nsrv, ninf, npend;
    bit act, restart, tmo;
    if (rst) begin
      m_st = 0; m_rr = 0; m_wd = 0; m_cyc = 0; m_js = 0; m_jc = 0;
      m_inf = 0; m_pend = 0; m_bs = 0; m_srv = 0; m_to = 0;
      return;
    end
    act = m_st == 1 || m_st == 2;
    restart = (m_st == 0 || m_st == 3) && ss;
    tmo = 0;
    nst = m_st;
    if (restart) nst = 1;
    else if (m_st == 1 && ood) nst = 2;
    else if (m_st == 2) begin
      if (m_inf == 0 && m_pend == 0 && has == 0 && idl == '1) nst = 3;
      else if (m_wd == TO - 1) begin nst = 3; tmo = 1; end
    end
    ninf = m_inf & ~dn;
    nbs = 0;
    for (int i = 0; i < N; i++)
      if (act && nst != 3 && has[i] && rdy[i] && !ninf[i]) begin nbs[i] = 1; ninf[i] = 1; end
    npend = m_pend;
    for (int i = 0; i < N; i++) if (has[i] || ood) npend[i] = 0;
    nsrv = 0;
    nrr = m_rr;
    if (m_st == 1 && !ood)
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (!has[i] && !m_inf[i] && !m_pend[i]) begin nsrv[i] = 1; npend[i] = 1; nrr = (i + 1) % N; break; end
      end
    nwd = (m_st == 2 && nst == 2) ? (dn != 0 ? 0 : m_wd + 1) : 0;
    if (restart) begin
      m_cyc = 0; m_js = 0; m_jc = 0; m_to = 0; ninf = 0; npend = 0; nrr = 0;
    end else begin
      m_js = sat(m_js + pop(m_bs));
      m_jc = sat(m_jc + pop(dn));
      if (act) m_cyc = sat(m_cyc + 1);
      if (tmo) m_to = 1;
    end
    m_st = nst; m_inf = ninf; m_pend = npend; m_bs = nbs; m_srv = nsrv; m_rr = nrr; m_wd = nwd;
  endtask
  task automatic check_all();
    check("bs_start", 32'(bs_start), 32'(m_bs));
    check("serve_reg", 32'(serve), 32'(m_srv));
    check("busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
    check("done", 32'(done), 32'(m_st == 3));
    check("timeout_err", 32'(terr), 32'(m_to));
    check("cycle_count", 32'(cyc), 32'(m_cyc));
    check("jobs_started", 32'(js), 32'(m_js));
    check("jobs_completed", 32'(jc), 32'(m_jc));
    check("led", 32'(led), 32'(m_cyc % (1 << LW)));
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic rand_in(input bit o);
    rdy = N'($urandom); dn = N'($urandom); idl = N'($urandom); has = N'($urandom); ood = o;
  endtask
  task automatic quiet();
    ss = 0; ood = 0; rdy = 0; dn = 0; idl = 0; has = 0;
  endtask
  initial begin
    int n, c0, jc0;
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    int n, c0, jc0;
    for (int i = 0; i < 3; i++) begin rand_in($urandom_range(0, 1)); ss = 1'($urandom); tick(); end
    check("rst_busy", 32'(busy), 0);
    check("rst_cyc", 32'(cyc), 0);
    rst = 0; quiet(); ss = 1; tick();
    check("start_busy", 32'(busy), 1);
    ss = 0;
    for (int k = 0; k < N; k++) begin tick(); check("rr_seq", 32'(serve), 32'(1 << k)); end
    tick(); check("rr_all_pending", 32'(serve), 0);
    has = 4'b0100; tick();
    has = 4'b0000; tick(); check("rr_pending_cleared", 32'(serve), 32'b0100);
    has = 4'b0001; rdy = 4'b0001; tick(); check("single_start", 32'(bs_start), 32'b0001);
    for (int i = 0; i < 3; i++) begin tick(); check("single_no_repeat", 32'(bs_start), 0); end
    check("single_js", 32'(js), 1);
    has = 4'b0010; rdy = 4'b0010; tick(); check("sim_first", 32'(bs_start), 32'b0010);
    jc0 = int'(jc); dn = 4'b0010; tick();
    check("sim_restart", 32'(bs_start), 32'b0010);
    check("sim_jc", 32'(jc), 32'(jc0 + 1));
    quiet(); ood = 1; tick(); check("drain_no_serve", 32'(serve), 0);
    tick(); tick();
    dn = m_inf; tick();
    dn = 0; idl = '1;
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    check("drain_done", 32'(done), 1);
    check("drain_terr", 32'(terr), 0);
    c0 = int'(cyc); tick(); tick();
    check("drain_cyc_frozen", 32'(cyc), 32'(c0));
    quiet(); ss = 1; tick();
    check("restart_cyc", 32'(cyc), 0);
    check("restart_js", 32'(js), 0);
    ss = 0; has = 4'b0001; rdy = 4'b0001; tick();
    ood = 1; has = 4'b0010;
    n = 0;
    while (!done && n < 30) begin rdy = (n == 8) ? 4'b0010 : 4'b0000; tick(); n++; end
    check("wd_cycles", 32'(n), 9);
    check("wd_terr", 32'(terr), 1);
    check("wd_no_start", 32'(bs_start), 0);
    quiet(); ss = 1; tick();
    check("wd_restart_terr", 32'(terr), 0);
    check("wd_restart_busy", 32'(busy), 1);
    ss = 0;
    for (int i = 0; i < 20; i++) begin rand_in(0); tick(); end
    rst = 1; tick(); rst = 0;
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_js", 32'(js), 0);
    quiet(); ss = 1; tick(); ss = 0;
    for (int i = 0; i < 1100; i++) begin rand_in(0); tick(); end
    check("cyc_saturated", 32'(cyc), 32'(MAXC));
    for (int e = 0; e < 20; e++) begin
      quiet(); ss = 1; tick(); ss = 0;
      for (int i = 0; i < 30; i++) begin
        rand_in(0);
        rst = ($urandom_range(0, 299) == 0);
        tick();
        rst = 0;
      end
      for (int i = 0; i < 5; i++) begin rand_in(1); tick(); end
      for (int i = 0; i < 40 && m_st != 3; i++) begin
        has = 0; ood = 1; rdy = N'($urandom);
        idl = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
        dn = (e % 4 == 3) ? '0 : (m_inf & N'($urandom));
        tick();
      end
      quiet(); ss = 1'($urandom); tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
